// File: rtl/csr_exec_unit.sv
// ----------------------------------------------------------------------------
// csr_exec_unit
//
// Initiator side of the CSR access interface. Runs one Zicsr instruction
// (CSRRW/CSRRS/CSRRC and their immediate forms) as an explicit
// read-then-write sequence against the CSR register file:
//   IDLE  -> accept request, latch operands
//   READ  -> present address, capture combinational read data / exception
//   WRITE -> single-cycle write strobe with the computed value
//   RESP  -> one-cycle done pulse carrying old value or trap
//
// Optional build macro:
//   CSR_RO_CHECK_EN - when defined, any instruction that would write a CSR
//                     whose addr[11:10] == 2'b11 (read-only space) traps with
//                     code 2 during READ and issues no write strobe. Pure
//                     reads of such addresses are still allowed. When not
//                     defined, legality is decided only by the CSR file's
//                     exc_en.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start/ready   request handshake from execute stage (accepted in IDLE)
//   flush         pipeline kill; only honoured while in READ
//   funct3        Zicsr funct3 (bit 2 selects immediate form)
//   csr_addr      target CSR address
//   rs1_idx       rs1 index, or uimm for immediate forms
//   rs1_val       rs1 register value
//   rd_idx        destination register index
//   r_csr_addr    address presented to the CSR file
//   csr_data      CSR file read data (combinational on r_csr_addr)
//   exc_en        CSR file illegal-access flag
//   exc_code      CSR file exception cause
//   exc_val       CSR file trap value
//   we_csr        write strobe to CSR file (only in WRITE)
//   w_csr_data    write data to CSR file
//   done          one-cycle completion pulse
//   rd_we         write old CSR value to rd (valid with done)
//   rd_out        latched rd index
//   rd_data       old CSR value
//   trap          trap indication (valid with done)
//   trap_code     trap cause
//   trap_val      trap value
// ----------------------------------------------------------------------------
module csr_exec_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            ready,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [4:0]      rd_idx,
    output logic [11:0]     r_csr_addr,
    input  logic [XLEN-1:0] csr_data,
    input  logic            exc_en,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_val,
    output logic            we_csr,
    output logic [XLEN-1:0] w_csr_data,
    output logic            done,
    output logic            rd_we,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] rd_data,
    output logic            trap,
    output logic [3:0]      trap_code,
    output logic [XLEN-1:0] trap_val
);

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    // Latched request
    logic [2:0]      f3_q;
    logic [11:0]     addr_q;
    logic [4:0]      rs1_idx_q;
    logic [XLEN-1:0] rs1_val_q;
    logic [4:0]      rd_q;

    // Results captured at the end of READ
    logic [XLEN-1:0] old_val_q;
    logic [XLEN-1:0] wdata_q;
    logic            trap_q;
    logic [3:0]      trap_code_q;
    logic [XLEN-1:0] trap_val_q;

    // Combinational decode of the latched request
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] new_val;
    logic            write_needed;
    logic            illegal_f3;
    logic            ro_hit;
    logic            trap_now;
    logic [3:0]      trap_code_now;
    logic [XLEN-1:0] trap_val_now;
    logic            accept;

    assign accept = (state == IDLE) && start;

    always_comb begin
        src = f3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
    end

    // New value uses the live read data so it can be registered at the
    // READ->WRITE edge together with old_val.
    always_comb begin
        new_val = csr_data;
        case (f3_q[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = csr_data | src;
            2'b11:   new_val = csr_data & ~src;
            default: new_val = csr_data;
        endcase
    end

    // Set/clear with a zero operand is a pure read: no write side effects.
    always_comb begin
        write_needed = (f3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
        illegal_f3   = (f3_q[1:0] == 2'b00);
    end

`ifdef CSR_RO_CHECK_EN
    always_comb begin
        ro_hit = (addr_q[11:10] == 2'b11) && write_needed;
    end
`else
    always_comb begin
        ro_hit = 1'b0;
    end
`endif

    // Trap priority: malformed funct3 first, then the CSR file's own
    // exception (cause/value passed through), then the read-only decode.
    always_comb begin
        trap_now      = 1'b0;
        trap_code_now = '0;
        trap_val_now  = '0;
        if (illegal_f3) begin
            trap_now      = 1'b1;
            trap_code_now = CAUSE_ILLEGAL;
            trap_val_now  = {{(XLEN-12){1'b0}}, addr_q};
        end else if (exc_en) begin
            trap_now      = 1'b1;
            trap_code_now = exc_code;
            trap_val_now  = exc_val;
        end else if (ro_hit) begin
            trap_now      = 1'b1;
            trap_code_now = CAUSE_ILLEGAL;
            trap_val_now  = {{(XLEN-12){1'b0}}, addr_q};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        we_csr     = 1'b0;
        done       = 1'b0;
        rd_we      = 1'b0;
        trap       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (!trap_now && write_needed) begin
                    state_next = WRITE;
                end else begin
                    state_next = RESP;
                end
            end
            WRITE: begin
                we_csr     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                done       = 1'b1;
                trap       = trap_q;
                rd_we      = !trap_q && (rd_q != 5'd0);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q        <= '0;
            addr_q      <= '0;
            rs1_idx_q   <= '0;
            rs1_val_q   <= '0;
            rd_q        <= '0;
            old_val_q   <= '0;
            wdata_q     <= '0;
            trap_q      <= 1'b0;
            trap_code_q <= '0;
            trap_val_q  <= '0;
        end else begin
            if (accept) begin
                f3_q      <= funct3;
                addr_q    <= csr_addr;
                rs1_idx_q <= rs1_idx;
                rs1_val_q <= rs1_val;
                rd_q      <= rd_idx;
            end
            if ((state == READ) && !flush) begin
                old_val_q   <= csr_data;
                wdata_q     <= new_val;
                trap_q      <= trap_now;
                trap_code_q <= trap_code_now;
                trap_val_q  <= trap_val_now;
            end
        end
    end

    assign r_csr_addr = addr_q;
    assign w_csr_data = wdata_q;
    assign rd_out     = rd_q;
    assign rd_data    = old_val_q;
    assign trap_code  = trap_code_q;
    assign trap_val   = trap_val_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_csr_exec_unit
//
// Self-checking bench for csr_exec_unit. Contains a behavioural CSR file
// (array with combinational read and an illegal-address map) attached to the
// DUT, and a reference array updated by the Zicsr rules to predict results.
// ----------------------------------------------------------------------------
module tb_csr_exec_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            ready;
    logic            flush;
    logic [2:0]      funct3;
    logic [11:0]     csr_addr;
    logic [4:0]      rs1_idx;
    logic [XLEN-1:0] rs1_val;
    logic [4:0]      rd_idx;
    logic [11:0]     r_csr_addr;
    logic [XLEN-1:0] csr_data;
    logic            exc_en;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_val;
    logic            we_csr;
    logic [XLEN-1:0] w_csr_data;
    logic            done;
    logic            rd_we;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] rd_data;
    logic            trap;
    logic [3:0]      trap_code;
    logic [XLEN-1:0] trap_val;

    // Behavioural CSR file
    logic [XLEN-1:0] csr_mem [0:4095];
    logic [XLEN-1:0] ref_mem [0:4095];
    logic            bad     [0:4095];
    logic [3:0]      bad_code;
    logic [XLEN-1:0] bad_val;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        csr_data = csr_mem[r_csr_addr];
        exc_en   = bad[r_csr_addr];
        exc_code = bad_code;
        exc_val  = bad_val;
    end

    always @(posedge clk) begin
        if (we_csr) csr_mem[r_csr_addr] <= w_csr_data;
    end

    csr_exec_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ready      (ready),
        .flush      (flush),
        .funct3     (funct3),
        .csr_addr   (csr_addr),
        .rs1_idx    (rs1_idx),
        .rs1_val    (rs1_val),
        .rd_idx     (rd_idx),
        .r_csr_addr (r_csr_addr),
        .csr_data   (csr_data),
        .exc_en     (exc_en),
        .exc_code   (exc_code),
        .exc_val    (exc_val),
        .we_csr     (we_csr),
        .w_csr_data (w_csr_data),
        .done       (done),
        .rd_we      (rd_we),
        .rd_out     (rd_out),
        .rd_data    (rd_data),
        .trap       (trap),
        .trap_code  (trap_code),
        .trap_val   (trap_val)
    );

    task automatic set_csr(input logic [11:0] a, input logic [XLEN-1:0] v);
        csr_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Issue one instruction and check every observable result against the
    // reference model. Bounded to 8 cycles after acceptance.
    task automatic run_op(input logic [2:0] f3, input logic [11:0] a,
                          input logic [4:0] r1, input logic [XLEN-1:0] v,
                          input logic [4:0] rd, input bit do_flush,
                          input string name);
        logic [XLEN-1:0] old, src, nv, tv, we_data, o_rd_data, o_tval;
        logic [3:0]      tc, o_tcode;
        logic [11:0]     we_addr;
        logic [4:0]      o_rd_out;
        bit              wn, tr, ro, do_write, o_rd_we, o_trap;
        int              exp_done, we_cnt, we_cyc, done_cnt, done_cyc, ready_cyc;

        old = ref_mem[a];
        src = f3[2] ? XLEN'(r1) : v;
        wn  = (f3[1:0] == 2'b01) || (r1 != 5'd0);
        case (f3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            2'b11:   nv = old & ~src;
            default: nv = old;
        endcase
`ifdef CSR_RO_CHECK_EN
        ro = (a[11:10] == 2'b11) && wn;
`else
        ro = 1'b0;
`endif
        tr = 1'b1; tc = 4'd2; tv = XLEN'(a);
        if (f3[1:0] == 2'b00) begin
            tr = 1'b1;
        end else if (bad[a]) begin
            tc = bad_code; tv = bad_val;
        end else if (!ro) begin
            tr = 1'b0;
        end
        do_write = !tr && wn;
        exp_done = do_write ? 3 : 2;

        we_cnt = 0; we_cyc = 0; done_cnt = 0; done_cyc = 0; ready_cyc = 0;
        we_data = '0; we_addr = '0; o_rd_we = 0; o_trap = 0; o_rd_out = '0;
        o_rd_data = '0; o_tcode = '0; o_tval = '0;

        @(negedge clk);
        tests++;
        if (ready !== 1'b1) begin
            fails++; $display("FAIL %s ready_idle got=%b exp=1", name, ready);
        end
        start = 1'b1; funct3 = f3; csr_addr = a; rs1_idx = r1; rs1_val = v; rd_idx = rd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                flush = do_flush;
                funct3 = $urandom; csr_addr = $urandom; rs1_val = {$urandom, $urandom};
            end else begin
                flush = 1'b0;
            end
            if (we_csr === 1'b1) begin
                we_cnt++; we_cyc = cyc; we_data = w_csr_data; we_addr = r_csr_addr;
            end
            if (done === 1'b1) begin
                done_cnt++; done_cyc = cyc; o_rd_we = rd_we; o_trap = trap;
                o_rd_out = rd_out; o_rd_data = rd_data; o_tcode = trap_code; o_tval = trap_val;
            end
            if (cyc > 1 && ready === 1'b1 && ready_cyc == 0) ready_cyc = cyc;
        end

        if (do_flush) begin
            tests++;
            if (we_cnt != 0 || done_cnt != 0 || ready_cyc != 2) begin
                fails++;
                $display("FAIL %s flush got we=%0d done=%0d ready_cyc=%0d exp 0/0/2",
                         name, we_cnt, done_cnt, ready_cyc);
            end
        end else begin
            ref_mem[a] = do_write ? nv : old;
            tests++;
            if (we_cnt != (do_write ? 1 : 0)) begin
                fails++; $display("FAIL %s we_count got=%0d exp=%0d", name, we_cnt, do_write ? 1 : 0);
            end
            if (do_write) begin
                tests++;
                if (we_cyc != 2 || we_data !== nv || we_addr !== a) begin
                    fails++;
                    $display("FAIL %s write got cyc=%0d data=%h addr=%h exp cyc=2 data=%h addr=%h",
                             name, we_cyc, we_data, we_addr, nv, a);
                end
            end
            tests++;
            if (done_cnt != 1 || done_cyc != exp_done) begin
                fails++;
                $display("FAIL %s done got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d",
                         name, done_cnt, done_cyc, exp_done);
            end
            tests++;
            if (ready_cyc != exp_done + 1) begin
                fails++; $display("FAIL %s ready_return got=%0d exp=%0d", name, ready_cyc, exp_done + 1);
            end
            tests++;
            if (o_trap !== tr || o_rd_we !== (!tr && rd != 5'd0) || o_rd_out !== rd) begin
                fails++;
                $display("FAIL %s resp got trap=%b rd_we=%b rd_out=%0d exp trap=%b rd_we=%b rd_out=%0d",
                         name, o_trap, o_rd_we, o_rd_out, tr, (!tr && rd != 5'd0), rd);
            end
            tests++;
            if (tr) begin
                if (o_tcode !== tc || o_tval !== tv) begin
                    fails++;
                    $display("FAIL %s trap_info got code=%0d val=%h exp code=%0d val=%h",
                             name, o_tcode, o_tval, tc, tv);
                end
            end else if (o_rd_data !== old) begin
                fails++; $display("FAIL %s rd_data got=%h exp=%h", name, o_rd_data, old);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (ready !== 1'b1 || we_csr !== 1'b0 || done !== 1'b0 || rd_we !== 1'b0 ||
            trap !== 1'b0 || r_csr_addr !== '0 || w_csr_data !== '0 || rd_data !== '0 ||
            trap_val !== '0 || trap_code !== '0 || rd_out !== '0) begin
            fails++;
            $display("FAIL reset_values got ready=%b we=%b done=%b rd_we=%b trap=%b addr=%h wd=%h rdd=%h tv=%h tc=%h rdo=%h exp ready=1 others 0",
                     ready, we_csr, done, rd_we, trap, r_csr_addr, w_csr_data, rd_data,
                     trap_val, trap_code, rd_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        set_csr(12'h040, 64'h1234);
        run_op(3'b001, 12'h040, 5'd1, 64'hDEAD, 5'd5, 0, "csrrw");
        set_csr(12'h004, 64'h00F);
        run_op(3'b010, 12'h004, 5'd2, 64'h0F0, 5'd6, 0, "csrrs");
        set_csr(12'h005, 64'h5A5A);
        run_op(3'b111, 12'h005, 5'd0, 64'hFFFF, 5'd7, 0, "csrrci_zero");
        run_op(3'b101, 12'h005, 5'd3, 64'h0, 5'd0, 0, "csrrwi_rd0");
    endtask

    task automatic test_traps();
        bad_code = 4'd2; bad_val = 64'h300;
        run_op(3'b001, 12'h300, 5'd1, 64'h77, 5'd4, 0, "exc_trap");
        bad_code = 4'd9; bad_val = 64'hCAFE_F00D;
        run_op(3'b010, 12'h7C0, 5'd0, 64'h0, 5'd4, 0, "exc_passthru");
        run_op(3'b000, 12'h040, 5'd1, 64'h1, 5'd4, 0, "funct3_000");
        run_op(3'b100, 12'h040, 5'd1, 64'h1, 5'd4, 0, "funct3_100");
    endtask

    task automatic test_read_only();
        set_csr(12'hC00, 64'h1111_2222);
        run_op(3'b001, 12'hC00, 5'd1, 64'h99, 5'd8, 0, "ro_write");
        run_op(3'b010, 12'hC00, 5'd0, 64'h99, 5'd8, 0, "ro_pure_read");
    endtask

    task automatic test_flush();
        set_csr(12'h041, 64'hABCD);
        run_op(3'b001, 12'h041, 5'd1, 64'h1, 5'd9, 1, "flush_read");
        run_op(3'b010, 12'h041, 5'd0, 64'h0, 5'd9, 0, "after_flush_read");
    endtask

    task automatic test_rst_during_write();
        set_csr(12'h050, 64'hAAAA);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b001; csr_addr = 12'h050; rs1_idx = 5'd1;
        rs1_val = 64'h5555; rd_idx = 5'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (we_csr !== 1'b1) begin
            fails++; $display("FAIL rst_wr_pre we_csr got=%b exp=1", we_csr);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (we_csr !== 1'b0 || done !== 1'b0 || ready !== 1'b1 || rd_data !== '0) begin
            fails++;
            $display("FAIL rst_wr_post got we=%b done=%b ready=%b rd_data=%h exp 0/0/1/0",
                     we_csr, done, ready, rd_data);
        end
        rst = 1'b0;
        // The strobe was high at the reset edge, so the CSR file took the write.
        ref_mem[12'h050] = 64'h5555;
        run_op(3'b010, 12'h050, 5'd0, 64'h0, 5'd3, 0, "after_rst");
    endtask

    task automatic test_random();
        logic [11:0] pool [8];
        logic [11:0] a;
        logic [2:0]  f3;
        logic [4:0]  r1, rd;
        pool = '{12'h040, 12'h004, 12'h005, 12'h300, 12'h7C0, 12'hC00, 12'hC01, 12'h100};
        for (int n = 0; n < 200; n++) begin
            a  = pool[$urandom_range(0, 7)];
            if (a == 12'h100) a = 12'h100 + 12'($urandom_range(0, 15));
            f3 = 3'($urandom_range(0, 7));
            if (f3[1:0] == 2'b00 && bad[a]) a = 12'h040;
            r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            bad_code = 4'($urandom);
            bad_val  = {$urandom, $urandom};
            run_op(f3, a, r1, {$urandom, $urandom}, rd, ($urandom_range(0, 9) == 0), "random");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; csr_addr = '0;
        rs1_idx = '0; rs1_val = '0; rd_idx = '0; bad_code = 4'd2; bad_val = '0;
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i] = {32'h5EED_0000 + 32'(i), 32'(i) * 32'h9E37_79B9};
            ref_mem[i] = csr_mem[i];
            bad[i]     = 1'b0;
        end
        bad[12'h300] = 1'b1;
        bad[12'h7C0] = 1'b1;

        test_reset();
        test_directed();
        test_traps();
        test_read_only();
        test_flush();
        test_rst_during_write();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

Initiator side of the CSR access interface. Executes one Zicsr instruction (CSRRW/CSRRS/CSRRC and immediate forms) as an explicit read-then-write sequence against the user CSR register file. Latches the CSR file's combinational read data and exception outputs, computes the write value, and issues a single-cycle write strobe. Returns the old CSR value for rd, or a trap, to the execute stage.

## Interface
Parameters:
- XLEN, 64, CSR data width; must match the CSR file.

Ports (one synchronous clock; synchronous, active-high reset):
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse from execute stage; sampled only in IDLE
- ready  out  1  high in IDLE; request accepted when start && ready
- flush  in  1  pipeline kill; abort rule in Operation
- funct3  in  3  Zicsr funct3
- csr_addr  in  12  target CSR address
- rs1_idx  in  5  rs1 index, or uimm in immediate forms
- rs1_val  in  XLEN  rs1 register value
- rd_idx  in  5  destination register index
- r_csr_addr  out  12  address to CSR file
- csr_data  in  XLEN  CSR file read data (combinational)
- exc_en  in  1  CSR file illegal-address flag
- exc_code  in  4  CSR file cause
- exc_val  in  XLEN  CSR file trap value
- we_csr  out  1  write strobe to CSR file
- w_csr_data  out  XLEN  write data to CSR file
- done  out  1  one-cycle completion pulse
- rd_we  out  1  write old value to rd; valid with done
- rd_out  out  5  latched rd_idx
- rd_data  out  XLEN  old CSR value
- trap  out  1  illegal-instruction trap; valid with done
- trap_code  out  4  cause (2 = illegal instruction)
- trap_val  out  XLEN  {52'b0, csr_addr}

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE -> READ on start: latch funct3, csr_addr, rs1_idx, rs1_val and rd_idx.
- READ:
  - Drive r_csr_addr from the latched address.
  - At the clock edge, latch csr_data into old_val and latch the exception signals.
  - Transition to WRITE if a write is needed and no trap is raised; otherwise to RESP.
- Operand: src = rs1_val for funct3[2]=0; src = {59'b0, rs1_idx} for funct3[2]=1.
- Write value by funct3[1:0]:
  - 01 (RW): src
  - 10 (RS): old_val | src
  - 11 (RC): old_val & ~src
- Write needed: always for RW/RWI; for RS/RC/RSI/RCI only when rs1_idx != 0.
- Trap (code 2, trap_val = {52'b0, addr}, no write, rd_we=0) when any of:
  - funct3 is 000 or 100
  - exc_en was set during READ; exc_code and exc_val pass through unchanged
  - the read-only check fires (see Configuration)
- WRITE: we_csr=1 for exactly one cycle; w_csr_data = computed value; r_csr_addr unchanged. -> RESP.
- RESP:
  - done=1 for one cycle.
  - rd_we = !trap && rd_idx != 0.
  - rd_data = old_val.
  - -> IDLE.
- flush in READ: go to IDLE; no write, no done. flush in WRITE or RESP is ignored; the write is the commit point.
- start outside IDLE is ignored; ready=0.

## Timing
- Accept at edge E0. READ occupies cycle 1. WRITE occupies cycle 2. done is high in cycle 3; ready returns in cycle 4.
- No write or trap: done in cycle 2.
- we_csr is never high outside WRITE. w_csr_data and r_csr_addr are stable throughout READ and WRITE.
- Reset values: ready=1; we_csr, done, rd_we, trap all 0; r_csr_addr=0; w_csr_data, rd_data, trap_val, trap_code, rd_out all 0; state IDLE.
- rst asserted in any state, including mid-WRITE, returns to IDLE on the next edge. we_csr drops that edge. No done is issued.

## Configuration
- CSR_RO_CHECK_EN defined: a write to a read-only address (addr[11:10]==2'b11) traps with code 2 in READ. No we_csr is issued. Pure reads of such an address (RS/RC with rs1_idx=0) are allowed.
- Not defined: no read-only decode. Legality is decided solely by the CSR file's exc_en.

## Test plan
- CSRRW addr 0x040, rs1_val 0xDEAD, rd 5, CSR holds 0x1234:
  - we_csr in cycle 2 with data 0xDEAD
  - done in cycle 3; rd_we=1, rd_data=0x1234
- CSRRS addr 0x004, rs1_val 0x0F0, CSR holds 0x00F: write 0x0FF.
- CSRRCI with uimm 0 on 0x005: no we_csr; done in cycle 2 with old value.
- CSRRW to 0x300 with CSR file exc_en=1: trap=1, code 2, trap_val 0x300, no we_csr, rd_we=0.
- With CSR_RO_CHECK_EN, CSRRW to 0xC00: trap in cycle 2, we_csr never asserted. With CSR_RO_CHECK_EN, CSRRS rs1=0 on 0xC00: no trap.
- Interrupt conditions:
  - flush in READ cycle: no write, no done, ready back in cycle 2.
  - rst asserted during WRITE: we_csr=0 on the next cycle, state IDLE, start accepted afterward.
